shift_seq: RTL and testbench
============================

SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 The module SHALL have parameter DIV, default 1, meaning clock cycles per serial bit; legal range 1..255.
REQ-002 The module SHALL have port clk, input, 1, meaning the clock; all state changes on posedge clk.
REQ-003 The module SHALL have port reset, input, 1, meaning reset, which is synchronous and active-high.
REQ-004 The module SHALL have port req0_valid, input, 1, meaning requester 0 offers a byte.
REQ-005 The module SHALL have port req0_data, input, 8, meaning the requester 0 byte.
REQ-006 The module SHALL have port req1_valid, input, 1, meaning requester 1 offers a byte.
REQ-007 The module SHALL have port req1_data, input, 8, meaning the requester 1 byte.
REQ-008 The module SHALL have port req0_ready, output, 1, meaning requester 0's byte is accepted this cycle.
REQ-009 The module SHALL have port req1_ready, output, 1, meaning requester 1's byte is accepted this cycle.
REQ-010 The module SHALL have port serial_out, output, 1, meaning the serial bit, MSB first.
REQ-011 The module SHALL have port busy, output, 1, meaning a frame is in progress.
REQ-012 The module SHALL have port done, output, 1, meaning a one-cycle end-of-frame pulse.
REQ-013 The module SHALL have port grant_id, output, 1, meaning the requester owning the current frame.

Function
REQ-014 The FSM SHALL have four states, IDLE, SHIFT, PARITY and DONE, and SHALL NOT reach any other state.
REQ-015 In IDLE, a transfer SHALL occur on a requester when its valid and its ready are both high.
REQ-016 The readys SHALL be one-hot or zero, and a ready SHALL be high only in IDLE with its valid high.
REQ-017 If exactly one requester is valid in IDLE, that requester SHALL be granted.
REQ-018 If both requesters are valid in IDLE, the requester other than the last-granted one SHALL be granted (round-robin).
REQ-019 On a transfer, the granted data SHALL be loaded into an 8-bit shift register, grant_id SHALL be set, and the next state SHALL be SHIFT.
REQ-020 In SHIFT, serial_out SHALL equal shift-register bit 7 and each bit SHALL be held for exactly DIV cycles.
REQ-021 In SHIFT, the shift register SHALL shift left by one, filling with 0, at the end of each bit period.
REQ-022 After 8 bit periods, the FSM SHALL go to PARITY if the parity feature is compiled in, otherwise to DONE.
REQ-023 In PARITY, serial_out SHALL equal the XOR of the 8 loaded data bits (even parity) for DIV cycles, and the next state SHALL be DONE.
REQ-024 In DONE, done SHALL be 1 and serial_out SHALL be 0 for one cycle, and the next state SHALL be IDLE.
REQ-025 Latency: for a transfer at edge t, bit 7 SHALL appear in cycle t+1 and done SHALL assert in cycle t+1+8*DIV (plus DIV with parity); the earliest next transfer SHALL be the following cycle.
REQ-026 busy SHALL be 1 in SHIFT, PARITY and DONE, and 0 in IDLE.
REQ-027 serial_out SHALL be 0 in IDLE.
REQ-028 The bit-period counter and the bit counter SHALL wrap to 0 at the end of each bit period and each frame respectively, with no stale carry into the next frame.
REQ-029 Changes on a requester's valid or data while busy SHALL be ignored, and a valid dropped before its ready SHALL NOT be granted.

Reset
REQ-030 While reset is high, the FSM SHALL be IDLE, the shift register and counters 0, serial_out, busy, done, grant_id and both readys 0, and last-granted SHALL be 1 so req0 wins the first tie.
REQ-031 A reset mid-frame SHALL abort the frame with no done pulse, and the first cycle after reset SHALL behave as post-reset IDLE.

Configuration
REQ-032 With macro SHIFT_SEQ_PARITY_EN defined, the PARITY state SHALL be included and a frame SHALL be 9 bit periods.
REQ-033 Without SHIFT_SEQ_PARITY_EN, PARITY logic SHALL be absent, the FSM SHALL go SHIFT->DONE, and a frame SHALL be 8 bit periods.

Verification
REQ-034 The bench SHALL cover a single frame: DIV=1, no parity, req0 sends 8'hA5 -> serial_out 1,0,1,0,0,1,0,1 in cycles t+1..t+8, done at t+9, grant_id 0.
REQ-035 The bench SHALL cover a tie: both valid after reset -> req0 granted first, then req1 in the next IDLE, and grants alternate while both remain valid.
REQ-036 The bench SHALL cover DIV: DIV=3, req1 sends 8'h80 -> serial_out 1 for 3 cycles then 0 for 21 cycles, done at t+25.
REQ-037 The bench SHALL cover parity: DIV=1, parity compiled in, send 8'h07 -> parity bit 1 at t+9 and done at t+10; send 8'h03 -> parity bit 0.
REQ-038 The bench SHALL cover reset abort: reset asserted at bit 4 of a frame -> no done pulse, serial_out 0 and busy 0 next cycle, and a fresh frame completes correctly.
REQ-039 The bench SHALL cover busy input: req0 data changed during the frame -> transmitted bits match the byte latched at transfer, and readys stay 0 until IDLE.

Source files
------------

// File: rtl/shift_seq.sv
// Two-requester round-robin byte serializer: MSB first, DIV clocks per bit, one-cycle done pulse.
// Optional even-parity bit after the data byte when SHIFT_SEQ_PARITY_EN is defined.
//
// state  | meaning
// IDLE   | waiting for a requester; readys are live only here
// SHIFT  | driving shift-register bit 7, DIV cycles per bit, 8 bits
// PARITY | driving the even parity of the loaded byte for DIV cycles (SHIFT_SEQ_PARITY_EN only)
// DONE   | one-cycle end-of-frame pulse, serial_out low
module shift_seq #(
  parameter int DIV = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req0_ready,
  output logic       req1_ready,
  output logic       serial_out,
  output logic       busy,
  output logic       done,
  output logic       grant_id
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd3;
`ifdef SHIFT_SEQ_PARITY_EN
  localparam logic [1:0] PARITY     = 2'd2;
  localparam logic [1:0] AFTER_DATA = PARITY;
`else
  localparam logic [1:0] AFTER_DATA = DONE;
`endif
  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

  logic [1:0] state;
  logic [7:0] shreg;
  logic [7:0] div_cnt;
  logic [2:0] bit_cnt;
  logic       gid_q;
  logic       last_grant;
  logic       idle;
  logic       pick1;
  logic       bit_end;

  // Outputs are gated by reset so they read as idle for every cycle reset is held.
  assign idle       = (state == IDLE) & ~reset;
  assign pick1      = req1_valid & (~req0_valid | ~last_grant);
  assign req0_ready = idle & req0_valid & ~pick1;
  assign req1_ready = idle & pick1;
  assign bit_end    = (div_cnt == DIV_LAST);
  assign grant_id   = gid_q & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= 8'd0;
      div_cnt    <= 8'd0;
      bit_cnt    <= 3'd0;
      gid_q      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready | req1_ready) begin
            state      <= SHIFT;
            shreg      <= req1_ready ? req1_data : req0_data;
            gid_q      <= req1_ready;
            last_grant <= req1_ready;
            div_cnt    <= 8'd0;
            bit_cnt    <= 3'd0;
          end
        end
        SHIFT: begin
          if (bit_end) begin
            div_cnt <= 8'd0;
            shreg   <= {shreg[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= AFTER_DATA;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
`ifdef SHIFT_SEQ_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            div_cnt <= 8'd0;
            state   <= DONE;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
`endif
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SHIFT_SEQ_PARITY_EN
  logic par_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      par_q <= 1'b0;
    end else if (req0_ready | req1_ready) begin
      par_q <= req1_ready ? ^req1_data : ^req0_data;
    end
  end
`endif

  always_comb begin
    serial_out = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    if (!reset) begin
      case (state)
        SHIFT: begin
          serial_out = shreg[7];
          busy       = 1'b1;
        end
`ifdef SHIFT_SEQ_PARITY_EN
        PARITY: begin
          serial_out = par_q;
          busy       = 1'b1;
        end
`endif
        DONE: begin
          done = 1'b1;
          busy = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq.sv
// Scoreboard bench for shift_seq: u1 runs DIV=1, u3 runs DIV=3; expected per-cycle
// {serial_out, busy, done} tuples are queued at stimulus time and popped each cycle.
module tb_shift_seq;

`ifdef SHIFT_SEQ_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       a_v0 = 0, a_v1 = 0, a_r0, a_r1, a_so, a_busy, a_done, a_gid;
  logic [7:0] a_d0 = 0, a_d1 = 0;
  logic       b_v0 = 0, b_v1 = 0, b_r0, b_r1, b_so, b_busy, b_done, b_gid;
  logic [7:0] b_d0 = 0, b_d1 = 0;

  int vectors = 0;
  int miscompares = 0;
  logic [2:0] sb[$];

  always #5 clk = ~clk;

  shift_seq #(.DIV(1)) u1 (
    .clk(clk), .reset(rst),
    .req0_valid(a_v0), .req0_data(a_d0), .req1_valid(a_v1), .req1_data(a_d1),
    .req0_ready(a_r0), .req1_ready(a_r1), .serial_out(a_so), .busy(a_busy),
    .done(a_done), .grant_id(a_gid)
  );

  shift_seq #(.DIV(3)) u3 (
    .clk(clk), .reset(rst),
    .req0_valid(b_v0), .req0_data(b_d0), .req1_valid(b_v1), .req1_data(b_d1),
    .req0_ready(b_r0), .req1_ready(b_r1), .serial_out(b_so), .busy(b_busy),
    .done(b_done), .grant_id(b_gid)
  );

  function automatic logic [2:0] obs(input int sel);
    return (sel != 0) ? {b_so, b_busy, b_done} : {a_so, a_busy, a_done};
  endfunction

  function automatic logic [2:0] ctl(input int sel);
    return (sel != 0) ? {b_r0, b_r1, b_gid} : {a_r0, a_r1, a_gid};
  endfunction

  task automatic push_frame(input logic [7:0] d, input int div);
    for (int b = 7; b >= 0; b--)
      for (int k = 0; k < div; k++) sb.push_back({d[b], 1'b1, 1'b0});
    if (PAR)
      for (int k = 0; k < div; k++) sb.push_back({^d, 1'b1, 1'b0});
    sb.push_back(3'b011);
  endtask

  task automatic set_req(input int sel, input int req, input logic v, input logic [7:0] d);
    if (sel == 0 && req == 0) begin a_v0 = v; a_d0 = d; end
    if (sel == 0 && req == 1) begin a_v1 = v; a_d1 = d; end
    if (sel == 1 && req == 0) begin b_v0 = v; b_d0 = d; end
    if (sel == 1 && req == 1) begin b_v1 = v; b_d1 = d; end
  endtask

  // Called at a negedge just after the transfer edge; cut < 0 runs the whole frame.
  task automatic drain(input int sel, input logic gid, input bit scramble, input int cut);
    logic [2:0] exp;
    int n = 0;
    while (sb.size() > 0 && (cut < 0 || n < cut)) begin
      exp = sb.pop_front();
      vectors++;
      if (obs(sel) !== exp) begin
        miscompares++;
        $display("FAIL frame_bit sel=%0d cyc=%0d got {so,busy,done}=%b want %b", sel, n + 1, obs(sel), exp);
      end
      vectors++;
      if (ctl(sel) !== {2'b00, gid}) begin
        miscompares++;
        $display("FAIL busy_ctl sel=%0d cyc=%0d got {r0,r1,gid}=%b want %b", sel, n + 1, ctl(sel), {2'b00, gid});
      end
      if (scramble) begin
        a_d0 = 8'($urandom);
        a_v0 = 1'($urandom_range(0, 1));
        a_v1 = 1'($urandom_range(0, 1));
      end
      n++;
      @(negedge clk);
    end
    if (cut < 0) begin
      vectors++;
      if (obs(sel) !== 3'b000) begin
        miscompares++;
        $display("FAIL idle_after sel=%0d got {so,busy,done}=%b want 000", sel, obs(sel));
      end
    end
  endtask

  task automatic start(input int sel, input int req, input logic [7:0] d, input int div,
                       input bit scramble, input int cut);
    int waited = 0;
    bit got = 0;
    set_req(sel, req, 1'b1, d);
    push_frame(d, div);
    while (!got && waited < 50) begin
      #1;
      if (ctl(sel)[2 - req] === 1'b1) got = 1;
      else begin
        @(negedge clk);
        waited++;
      end
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL ready_timeout sel=%0d req=%0d got ready=0 want 1 within 50 cycles", sel, req);
      sb.delete();
      set_req(sel, req, 1'b0, d);
    end else begin
      @(posedge clk);
      #1 set_req(sel, req, 1'b0, d);
      @(negedge clk);
      drain(sel, 1'(req), scramble, cut);
    end
  endtask

  task automatic test_reset;
    a_v0 = 1; a_v1 = 1; b_v0 = 1; b_v1 = 1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({obs(0), ctl(0)} !== 6'd0) begin
      miscompares++;
      $display("FAIL reset_u1 got {so,busy,done,r0,r1,gid}=%b want 000000", {obs(0), ctl(0)});
    end
    vectors++;
    if ({obs(1), ctl(1)} !== 6'd0) begin
      miscompares++;
      $display("FAIL reset_u3 got {so,busy,done,r0,r1,gid}=%b want 000000", {obs(1), ctl(1)});
    end
    rst = 0;
    a_v0 = 0; a_v1 = 0; b_v0 = 0; b_v1 = 0;
    @(negedge clk);
  endtask

  task automatic test_tie;
    logic g;
    a_v0 = 1; a_d0 = 8'h5A; a_v1 = 1; a_d1 = 8'hC3;
    for (int i = 0; i < 4; i++) begin
      g = 1'(i % 2);
      #1;
      vectors++;
      if ({a_r0, a_r1} !== {~g, g}) begin
        miscompares++;
        $display("FAIL tie_ready round=%0d got {r0,r1}=%b want %b", i, {a_r0, a_r1}, {~g, g});
      end
      push_frame(g ? a_d1 : a_d0, 1);
      @(posedge clk);
      @(negedge clk);
      drain(0, g, 1'b0, -1);
    end
    a_v0 = 0; a_v1 = 0;
  endtask

  task automatic test_single;
    start(0, 0, 8'hA5, 1, 1'b0, -1);
    start(0, 1, 8'h01, 1, 1'b0, -1);
  endtask

  task automatic test_div;
    start(1, 1, 8'h80, 3, 1'b0, -1);
  endtask

  task automatic test_busy_input;
    start(0, 0, 8'h3C, 1, 1'b1, -1);
    a_v0 = 0; a_v1 = 0;
    @(negedge clk);
  endtask

  task automatic test_parity;
    start(0, 0, 8'h07, 1, 1'b0, -1);
    start(0, 0, 8'h03, 1, 1'b0, -1);
  endtask

  task automatic test_reset_abort;
    int dones = 0;
    start(0, 0, 8'h96, 1, 1'b0, 4);
    rst = 1;
    @(posedge clk);
    if (a_done) dones++;
    @(negedge clk);
    if (a_done) dones++;
    vectors++;
    if ({a_so, a_busy, dones != 0} !== 3'b000) begin
      miscompares++;
      $display("FAIL abort got {so,busy,done_seen}=%b want 000", {a_so, a_busy, dones != 0});
    end
    rst = 0;
    sb.delete();
    @(negedge clk);
    a_v0 = 1; a_v1 = 1;
    #1;
    vectors++;
    if ({a_r0, a_r1, a_busy} !== 3'b100) begin
      miscompares++;
      $display("FAIL post_reset_tie got {r0,r1,busy}=%b want 100", {a_r0, a_r1, a_busy});
    end
    a_v1 = 0;
    start(0, 0, 8'h69, 1, 1'b0, -1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_tie();
    test_single();
    test_div();
    test_busy_input();
`ifdef SHIFT_SEQ_PARITY_EN
    test_parity();
`endif
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
